// File: rtl/life_pkg.sv
// Shared types and default board geometry for the Life scan-out block.
package life_pkg;

  localparam int X_DEF     = 8;
  localparam int Y_DEF     = 8;
  localparam int LOG2X_DEF = 3;
  localparam int LOG2Y_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } life_state_e;

endpackage

// File: rtl/life_xy_counter.sv
// Raster x/y counter with row-end (eol) and frame-end (eof) decode.
module life_xy_counter
  import life_pkg::*;
#(
  parameter int X     = X_DEF,
  parameter int Y     = Y_DEF,
  parameter int LOG2X = LOG2X_DEF,
  parameter int LOG2Y = LOG2Y_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [LOG2X-1:0] x,
  output logic [LOG2Y-1:0] y,
  output logic             eol,
  output logic             eof
);

  // Wrap is decoded from X-1/Y-1 so non power-of-two boards work.
  assign eol = (x == LOG2X'(X - 1));
  assign eof = eol && (y == LOG2Y'(Y - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + LOG2Y'(1);
      end else begin
        x <= x + LOG2X'(1);
      end
    end
  end

endmodule

// File: rtl/life_scanout.sv
// Streams a captured Life board one cell per valid/ready transfer in raster order.
// Optional build macro LIFE_SCANOUT_DROPCNT_EN adds drop_cnt (ignored gen_valid pulses).
module life_scanout
  import life_pkg::*;
#(
  parameter int X     = X_DEF,
  parameter int Y     = Y_DEF,
  parameter int LOG2X = LOG2X_DEF,
  parameter int LOG2Y = LOG2Y_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [X*Y-1:0]   board,
  input  logic             gen_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [LOG2X-1:0] out_x,
  output logic [LOG2Y-1:0] out_y,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
`ifdef LIFE_SCANOUT_DROPCNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output life_state_e      dbg_state
);

  // Handshake: a cell moves on every rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, all out_* signals hold.

  localparam int N  = X * Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  life_state_e      state_q, state_d;
  logic [N-1:0]     snap_q;
  logic [LOG2X-1:0] x;
  logic [LOG2Y-1:0] y;
  logic             eol, eof;
  logic             transfer, last_xfer, capture;
  logic [IW-1:0]    idx;

  assign transfer  = (state_q == SCAN) && out_ready;
  assign last_xfer = transfer && eof;
  // A new generation is only accepted when idle or on the frame's final edge.
  assign capture   = gen_valid && ((state_q == IDLE) || last_xfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) snap_q <= board;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SCAN;
      SCAN:    if (last_xfer) state_d = capture ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  life_xy_counter #(
    .X     (X),
    .Y     (Y),
    .LOG2X (LOG2X),
    .LOG2Y (LOG2Y)
  ) u_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (capture),
    .step  (transfer),
    .x     (x),
    .y     (y),
    .eol   (eol),
    .eof   (eof)
  );

  assign idx       = IW'(y) * IW'(X) + IW'(x);
  assign out_valid = (state_q == SCAN);
  assign busy      = out_valid;
  assign out_data  = out_valid && snap_q[idx];
  assign out_x     = x;
  assign out_y     = y;
  assign out_sof   = out_valid && (x == '0) && (y == '0);
  assign out_eol   = out_valid && eol;
  assign out_eof   = out_valid && eof;
  assign dbg_state = state_q;

`ifdef LIFE_SCANOUT_DROPCNT_EN
  logic ignored;
  assign ignored = gen_valid && (state_q == SCAN) && !last_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (ignored && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/life_scanout.md
LIFE_SCANOUT -- requirements
Module: life_scanout

Interface
REQ-001 Parameters SHALL be (name, default, meaning): X, 8, board width in cells; Y, 8, board height in cells; LOG2X, 3, width of out_x; LOG2Y, 3, width of out_y.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 board  input  X*Y  current generation; cell (x,y) at bit y*X+x, 1 = alive.
REQ-005 gen_valid  input  1  one-cycle pulse: board holds a complete new generation.
REQ-006 busy  output  1  high while a frame is being streamed.
REQ-007 out_valid  output  1  out_data/out_x/out_y/flags are valid.
REQ-008 out_ready  input  1  sink accepts the current cell.
REQ-009 out_data  output  1  cell state at (out_x,out_y).
REQ-010 out_x  output  LOG2X  column of current cell; out_y  output  LOG2Y  row of current cell.
REQ-011 out_sof / out_eol / out_eof  output  1 each  first cell of frame / last cell of row / last cell of frame.

Function
REQ-012 FSM SHALL have exactly two states: IDLE (busy=0, out_valid=0) and SCAN (busy=1, out_valid=1).
REQ-013 In IDLE, gen_valid=1 SHALL capture board into an internal X*Y snapshot, set x=y=0 and enter SCAN on the same edge; out_valid SHALL rise the cycle after the gen_valid pulse.
REQ-014 A transfer SHALL occur on any edge with out_valid=1 and out_ready=1; out_data, out_x, out_y and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 On each transfer, x SHALL increment; at x=X-1, x SHALL wrap to 0 and y SHALL increment.
REQ-016 out_data SHALL equal snapshot bit out_y*X+out_x; changes to board during SCAN SHALL NOT affect the frame.
REQ-017 out_sof = (x==0 && y==0); out_eol = (x==X-1); out_eof = (x==X-1 && y==Y-1), all gated by out_valid.
REQ-018 Transfer of the out_eof cell SHALL return the FSM to IDLE, unless gen_valid=1 on that same edge, in which case the new board SHALL be captured and SCAN SHALL continue with x=y=0 without a bubble cycle.
REQ-019 gen_valid in SCAN, other than on the REQ-018 edge, SHALL be ignored and SHALL NOT disturb the frame in progress.
REQ-020 Counter widths SHALL be LOG2X/LOG2Y; X and Y need not be powers of two, and wrap SHALL occur at X-1/Y-1, never at the counter's natural overflow.
REQ-021 A frame SHALL consist of exactly X*Y transfers.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately force IDLE: busy=0, out_valid=0, out_x=0, out_y=0, flags=0, snapshot cleared to 0, drop counter (if present) cleared to 0.
REQ-023 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait for a new gen_valid.

Configuration
REQ-024 Macro LIFE_SCANOUT_DROPCNT_EN: when defined, output drop_cnt (8 bits) SHALL count gen_valid pulses ignored per REQ-019, saturating at 255 and cleared only by reset; when undefined, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-025 The FSM state type and the default X/Y/LOG2X/LOG2Y constants SHALL live in shared package life_pkg.
REQ-026 The x/y wrap counter with eol/eof generation SHALL be a sub-module, life_xy_counter.

Verification
REQ-027 X=Y=8; gen_valid pulse with board bit 0 and bit 63 set, out_ready=1 -> 64 transfers; out_data=1 only at (0,0) and (7,7); out_sof on the first transfer, out_eof on the 64th; busy=0 the cycle after.
REQ-028 Same frame, out_ready toggled 1/0 every cycle -> 64 transfers over 128 cycles; outputs held stable across each stall.
REQ-029 Board changed to all-ones during SCAN -> streamed data still matches the captured snapshot.
REQ-030 gen_valid on the eof transfer edge -> next cycle shows out_sof=1 with (0,0) of the new board and no out_valid gap; gen_valid x3 mid-frame -> frame unaffected, drop_cnt=3 (macro defined).
REQ-031 X=5, Y=3 -> out_x sequence 0..4 wrapping and out_y 0..2; out_eol on every 5th transfer; 15 transfers total.
REQ-032 rst_n=0 asserted at transfer 20 -> out_valid=0 without waiting for a clock edge; after release, no output until gen_valid.
